// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants, state type and frame timing
package midi_pkg;

    // Tick divider terminal count: 48 MHz / (95+1) = 500 kHz, 16 ticks per 31 250 baud bit
    localparam int MidiDiv = 95;

    // Start + 8 data + stop
    localparam int MIDI_BITS_PER_FRAME = 10;

    // Oversample ticks per serial bit
    localparam int MIDI_TICKS_PER_BIT = 16;

    // Channel-voice status bytes shared with the receiver and debug probes
    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small power-of-two synchronous FIFO with occupancy count
module byte_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [Width-1:0]         i_data,
    input  logic                     i_pop,
    output logic [Width-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(Depth):0]   o_count
);

    localparam int AddrW = $clog2(Depth);
    localparam logic [AddrW:0] FullCount = Depth[AddrW:0];

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Overflowing pushes and underflowing pops are ignored rather than corrupting state
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    assign o_full  = (o_count == FullCount);
    assign o_empty = (o_count == '0);
    assign o_data  = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                o_count <= o_count + 1'b1;
            end else if (do_pop && !do_push) begin
                o_count <= o_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI serial transmitter, 31 250 baud 8N1 from a byte FIFO
module midi_tx
    import midi_pkg::*;
#(
    parameter int TickDiv   = MidiDiv,
    parameter int FifoDepth = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int CntW = $clog2(FifoDepth) + 1;
    localparam int DivW = (TickDiv < 1) ? 1 : $clog2(TickDiv + 1);
    localparam logic [CntW-1:0] FullCount = FifoDepth[CntW-1:0];
    localparam logic [DivW-1:0] DivLast   = TickDiv[DivW-1:0];
    localparam logic [3:0]      TickLast  = 4'(MIDI_TICKS_PER_BIT - 1);

    tx_state_t         state;
    logic [DivW-1:0]   div_cnt;
    logic [3:0]        tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;

    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_count;

    logic              div_end;
    logic              bit_end;

    byte_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_data  (i_data),
        .i_pop   (fifo_pop),
        .o_data  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Ready comes from the registered occupancy only, so a pop never opens a slot in the same cycle
    assign o_ready   = (fifo_count < FullCount);
    assign fifo_push = i_valid && !fifo_full;
    assign o_busy    = (state != IDLE) || !fifo_empty;

    assign div_end = (div_cnt == DivLast);
    assign bit_end = div_end && (tick_cnt == TickLast);

    // A new frame is loaded from IDLE, or straight out of a finished stop bit for gapless streaming
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));

    // Frame sequencer: oversample timing, shift register and registered serial line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_tx     <= 1'b1;
        end else begin
            if (state != IDLE) begin
                if (div_end) begin
                    div_cnt  <= '0;
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        state    <= START;
                        shreg    <= fifo_dout;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        o_tx     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        o_tx    <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            o_tx    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            state    <= START;
                            shreg    <= fifo_dout;
                            div_cnt  <= '0;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            o_tx     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - self-checking bench for midi_tx at default and fast tick rates
module tb_midi_tx;
    import midi_pkg::*;

    localparam int Depth   = 4;
    localparam int FastDiv = 3;
    localparam int SlowBit = 16 * (MidiDiv + 1);
    localparam int FastBit = 16 * (FastDiv + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       started = 1'b0;
    logic       valid [2] = '{1'b0, 1'b0};
    logic [7:0] data  [2] = '{8'h00, 8'h00};
    logic       ready [2];
    logic       tx    [2];
    logic       busy  [2];

    int checks = 0;
    int errors = 0;

    int         bitp [2] = '{SlowBit, FastBit};
    longint     cyc = 0;
    logic [7:0] m_buf [2][256];
    int         m_head [2] = '{0, 0};
    int         m_tail [2] = '{0, 0};
    logic       m_active [2] = '{1'b0, 1'b0};
    longint     m_start [2] = '{0, 0};
    logic [7:0] m_byte [2];
    logic       m_acc [2] = '{1'b0, 1'b0};
    longint     m_acc_cyc [2] = '{0, 0};

    always #5 clk = ~clk;

    midi_tx #(.TickDiv(MidiDiv), .FifoDepth(Depth)) dut_slow (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(ready[0]),
        .i_data(data[0]), .o_tx(tx[0]), .o_busy(busy[0])
    );

    midi_tx #(.TickDiv(FastDiv), .FifoDepth(Depth)) dut_fast (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(ready[1]),
        .i_data(data[1]), .o_tx(tx[1]), .o_busy(busy[1])
    );

    task automatic check(string name, int c, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d cycle %0d: got %0h expected %0h", name, c, cyc, act, exp);
        end
    endtask

    // Reference: byte queue plus frame start times; line value follows from elapsed bit periods
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_head[c] = 0;
                m_tail[c] = 0;
                m_active[c] = 1'b0;
                m_acc[c] = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            for (int c = 0; c < 2; c++) begin
                int pend;
                pend = m_tail[c] - m_head[c];
                m_acc[c] = valid[c] && (pend < Depth);
                if (m_active[c] && (cyc - m_start[c] == 10 * longint'(bitp[c])))
                    m_active[c] = 1'b0;
                if (!m_active[c] && pend > 0) begin
                    m_byte[c] = m_buf[c][m_head[c] % 256];
                    m_head[c]++;
                    m_active[c] = 1'b1;
                    m_start[c] = cyc;
                end
                if (m_acc[c]) begin
                    m_buf[c][m_tail[c] % 256] = data[c];
                    m_tail[c]++;
                    m_acc_cyc[c] = cyc;
                end
            end
        end
    end

    function automatic logic exp_tx(int c);
        longint k;
        if (!m_active[c]) return 1'b1;
        k = (cyc - m_start[c]) / longint'(bitp[c]);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_byte[c][int'(k - 1)];
    endfunction

    // Every-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        if (started && !rst) begin
            for (int c = 0; c < 2; c++) begin
                check("tx", c, tx[c], exp_tx(c));
                check("busy", c, busy[c], m_active[c] || (m_tail[c] != m_head[c]));
                check("ready", c, ready[c], (m_tail[c] - m_head[c]) < Depth);
            end
        end
    end

    task automatic goto_edge(longint t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int c, logic [7:0] b);
        int budget;
        budget = 20 * 10 * bitp[c];
        valid[c] = 1'b1;
        data[c] = b;
        do begin
            @(posedge clk);
            #1;
            budget--;
        end while (!m_acc[c] && budget > 0);
        valid[c] = 1'b0;
        if (!m_acc[c]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ch%0d: byte %0h never accepted", c, b);
        end
    endtask

    task automatic wait_idle(int c);
        int budget;
        budget = 12 * 10 * bitp[c];
        while ((m_active[c] || m_tail[c] != m_head[c]) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout ch%0d: still busy expected idle", c);
        end
    endtask

    // pat[k] is the literal line level for bit period k of a frame starting at edge s
    task automatic check_frame(int c, logic [9:0] pat, longint s, int bp);
        for (int k = 0; k < 10; k++) begin
            goto_edge(s + longint'(k * bp));
            check("frame_first", c, tx[c], pat[k]);
            goto_edge(s + longint'(k * bp + bp - 1));
            check("frame_last", c, tx[c], pat[k]);
        end
    endtask

    task automatic slow_thread();
        longint a;
        send(0, MIDI_NOTE_ON);
        a = m_acc_cyc[0];
        check("lat_still_high", 0, tx[0], 1'b1);
        check("busy_rise", 0, busy[0], 1'b1);
        check_frame(0, 10'b1100100000, a + 1, SlowBit);
        check("busy_in_stop", 0, busy[0], 1'b1);
        goto_edge(a + 1 + 10 * SlowBit);
        check("busy_fall", 0, busy[0], 1'b0);
        check("idle_line", 0, tx[0], 1'b1);
    endtask

    task automatic fast_thread();
        longint a;
        longint n;
        logic [7:0] b [6];
        // note-on burst: 30 contiguous bit periods
        send(1, MIDI_NOTE_ON);
        a = m_acc_cyc[1];
        send(1, 8'h3C);
        send(1, 8'h64);
        goto_edge(a + 30 * FastBit);
        check("burst_last_stop", 1, tx[1], 1'b1);
        check("burst_busy_end", 1, busy[1], 1'b1);
        goto_edge(a + 1 + 30 * FastBit);
        check("burst_idle", 1, busy[1], 1'b0);
        wait_idle(1);

        // divider: 64-clock bits, alternating data
        send(1, 8'h55);
        a = m_acc_cyc[1];
        check_frame(1, 10'b1010101010, a + 1, FastBit);
        wait_idle(1);

        // backpressure: 1 in flight + 4 queued, 6th waits for the pop
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        send(1, b[0]);
        n = m_acc_cyc[1];
        for (int i = 1; i < 5; i++) send(1, b[i]);
        check("bp_ready_low", 1, ready[1], 1'b0);
        valid[1] = 1'b1;
        data[1] = b[5];
        goto_edge(n + 10 * FastBit);
        check("bp_ready_before_pop", 1, ready[1], 1'b0);
        goto_edge(n + 1 + 10 * FastBit);
        check("bp_refused_on_pop", 1, m_acc[1], 1'b0);
        check("bp_ready_after_pop", 1, ready[1], 1'b1);
        goto_edge(n + 2 + 10 * FastBit);
        valid[1] = 1'b0;
        check("bp_sixth_accept", 1, m_acc[1], 1'b1);
        check("bp_full_again", 1, ready[1], 1'b0);
        wait_idle(1);

        // randomised traffic with occasional idle gaps
        for (int i = 0; i < 24; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 900)) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(1, 8'($urandom));
        end
        wait_idle(1);
    endtask

    initial begin
        longint a;
        #2 rst = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            check("rst_tx", c, tx[c], 1'b1);
            check("rst_ready", c, ready[c], 1'b1);
            check("rst_busy", c, busy[c], 1'b0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        started = 1'b1;

        fork
            slow_thread();
            fast_thread();
        join
        wait_idle(0);
        wait_idle(1);

        // reset during data bit 3 with two bytes queued
        send(1, 8'h11);
        a = m_acc_cyc[1];
        send(1, 8'h22);
        send(1, 8'h33);
        goto_edge(a + 1 + 4 * FastBit + 10);
        check("pre_rst_bit3", 1, tx[1], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", 1, tx[1], 1'b1);
        check("midrst_busy", 1, busy[1], 1'b0);
        check("midrst_ready", 1, ready[1], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (30 * FastBit) @(posedge clk);
        #1;
        check("post_rst_quiet_tx", 1, tx[1], 1'b1);
        check("post_rst_quiet_busy", 1, busy[1], 1'b0);
        send(1, MIDI_NOTE_OFF);
        a = m_acc_cyc[1];
        check_frame(1, 10'b1100000000, a + 1, FastBit);
        wait_idle(1);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
